// File: rtl/capture_sequencer.sv
// Single-frame capture sequencer: arms on a start edge, discards settle frames,
// lets the pixel writer fill one frame, then hands the memory port to the reader.
module capture_sequencer #(
  parameter int SETTLE_FRAMES = 300,
  parameter int FRAME_X       = 143,
  parameter int FRAME_Y       = 34,
  parameter int DEPTH         = 19200
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iStart,
  input  logic [12:0] iX,
  input  logic [12:0] iY,
  input  logic        iWrReq,
  input  logic [14:0] iWrAddr,
  input  logic [9:0]  iWrData,
  input  logic        iRdReq,
  input  logic [14:0] iRdAddr,
  input  logic        iRdDone,
  input  logic [9:0]  iMemQ,
  output logic [14:0] oMemAddr,
  output logic [9:0]  oMemData,
  output logic        oMemWE,
  output logic [9:0]  oRdData,
  output logic        oRdValid,
  output logic        oCapEn,
  output logic        oDone,
  output logic        oOverrun,
  output logic [15:0] oWrCount,
  output logic        oLed
);

  localparam logic [15:0] DEPTH_L  = 16'(DEPTH);
  localparam logic [15:0] SETTLE_L = 16'(SETTLE_FRAMES);
  localparam logic [12:0] FX       = 13'(FRAME_X);
  localparam logic [12:0] FY       = 13'(FRAME_Y);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, READOUT} state_t;

  state_t      state, state_next;
  logic        start_p0, start_p1, arm;
  logic        match, match_p0, fs_p0;
  logic [15:0] frame_cnt;
  logic [15:0] wr_count;
  logic        overrun;
  logic        wr_acc, wr_ok, rd_acc;
  logic [14:0] mem_addr_p0;
  logic [9:0]  mem_data_p0;
  logic        mem_we_p0;
  logic        vld_p0, vld_p1;
  logic        cap_en_p0;

  assign arm    = start_p0 && !start_p1;
  assign match  = (iX == FX) && (iY == FY);
  assign wr_acc = (state == CAPTURE) && iWrReq;
  assign wr_ok  = wr_acc && ({1'b0, iWrAddr} < DEPTH_L);
  assign rd_acc = (state == READOUT) && iRdReq;

  always_comb begin
    state_next = state;
    oDone      = 1'b0;
    oLed       = 1'b0;
    case (state)
      IDLE:    if (arm) state_next = SETTLE;
      SETTLE: begin
        if (!start_p0)                          state_next = IDLE;
        else if (fs_p0 && frame_cnt == SETTLE_L) state_next = CAPTURE;
      end
      CAPTURE: begin
        oLed = 1'b1;
        if (!start_p0)  state_next = IDLE;
        else if (fs_p0) state_next = READOUT;
      end
      READOUT: begin
        oDone = 1'b1;
        oLed  = 1'b1;
        if (iRdDone) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Input conditioning: start edge detect and frame-start pulse (stage p0).
  // Start registers reset high so a switch left on through reset does not arm.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      start_p0 <= 1'b1;
      start_p1 <= 1'b1;
      match_p0 <= 1'b0;
      fs_p0    <= 1'b0;
    end else begin
      start_p0 <= iStart;
      start_p1 <= start_p0;
      match_p0 <= match;
      fs_p0    <= match && !match_p0;
    end
  end

  // Sequencer state, frame counter and capture statistics.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      frame_cnt <= '0;
      wr_count  <= '0;
      overrun   <= 1'b0;
      cap_en_p0 <= 1'b0;
    end else begin
      state     <= state_next;
      cap_en_p0 <= (state == CAPTURE) && (state_next == CAPTURE);
      if (state == IDLE && arm) begin
        frame_cnt <= '0;
        wr_count  <= '0;
        overrun   <= 1'b0;
      end else begin
        if (state == SETTLE && fs_p0) frame_cnt <= frame_cnt + 16'd1;
        if (wr_ok && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if (wr_acc && !wr_ok) overrun <= 1'b1;
      end
    end
  end

  // Memory port register stage (p0) and read-valid pipeline (p1).
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mem_addr_p0 <= '0;
      mem_data_p0 <= '0;
      mem_we_p0   <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      mem_we_p0 <= wr_ok;
      vld_p0    <= rd_acc;
      vld_p1    <= vld_p0;
      if (wr_ok) begin
        mem_addr_p0 <= iWrAddr;
        mem_data_p0 <= iWrData;
      end else if (rd_acc) begin
        mem_addr_p0 <= iRdAddr;
      end
    end
  end

  assign oMemAddr = mem_addr_p0;
  assign oMemData = mem_data_p0;
  assign oMemWE   = mem_we_p0;
  assign oRdData  = iMemQ;
  assign oRdValid = vld_p1;
  assign oCapEn   = cap_en_p0;
  assign oOverrun = overrun;
  assign oWrCount = wr_count;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a one-cycle-latency memory model.
module tb_capture_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iStart;
  logic [12:0] iX, iY;
  logic        iWrReq;
  logic [14:0] iWrAddr;
  logic [9:0]  iWrData;
  logic        iRdReq;
  logic [14:0] iRdAddr;
  logic        iRdDone;
  logic [9:0]  iMemQ;
  logic [14:0] oMemAddr;
  logic [9:0]  oMemData;
  logic        oMemWE;
  logic [9:0]  oRdData;
  logic        oRdValid;
  logic        oCapEn;
  logic        oDone;
  logic        oOverrun;
  logic [15:0] oWrCount;
  logic        oLed;

  int vectors = 0;
  int miscompares = 0;

  capture_sequencer #(
    .SETTLE_FRAMES(3),
    .FRAME_X(143),
    .FRAME_Y(34),
    .DEPTH(19200)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iX(iX), .iY(iY),
    .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .iRdReq(iRdReq), .iRdAddr(iRdAddr), .iRdDone(iRdDone), .iMemQ(iMemQ),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemWE(oMemWE),
    .oRdData(oRdData), .oRdValid(oRdValid), .oCapEn(oCapEn), .oDone(oDone),
    .oOverrun(oOverrun), .oWrCount(oWrCount), .oLed(oLed)
  );

  always #5 iCLK = ~iCLK;

  logic [9:0] mem [0:32767];
  always @(posedge iCLK) begin
    if (oMemWE) mem[oMemAddr] <= oMemData;
    iMemQ <= mem[oMemAddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic frame(input int hold);
    iX = 13'd143; iY = 13'd34;
    cyc(hold);
    iX = 13'd0; iY = 13'd0;
    cyc(1);
  endtask

  task automatic wr(input logic [14:0] a, input logic [9:0] d);
    iWrReq = 1'b1; iWrAddr = a; iWrData = d;
    cyc(1);
    iWrReq = 1'b0;
  endtask

  task automatic arm_and_capture();
    iStart = 1'b0;
    cyc(2);
    iStart = 1'b1;
    cyc(3);
    repeat (4) frame(1);
    cyc(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    iRST_N = 1'b0; iStart = 1'b1;
    iX = 13'd143; iY = 13'd34;
    iWrReq = 1'b1; iWrAddr = 15'd5; iWrData = 10'd7;
    iRdReq = 1'b1; iRdAddr = 15'd6; iRdDone = 1'b0;
    cyc(3);
    chk("rst_we",     32'(oMemWE),   0);
    chk("rst_addr",   32'(oMemAddr), 0);
    chk("rst_data",   32'(oMemData), 0);
    chk("rst_rdvld",  32'(oRdValid), 0);
    chk("rst_capen",  32'(oCapEn),   0);
    chk("rst_done",   32'(oDone),    0);
    chk("rst_ovr",    32'(oOverrun), 0);
    chk("rst_cnt",    32'(oWrCount), 0);
    chk("rst_led",    32'(oLed),     0);

    iRST_N = 1'b1; iWrReq = 1'b0; iRdReq = 1'b0;
    cyc(2);
    repeat (4) frame(1);
    cyc(1);
    chk("noarm_led",   32'(oLed),   0);
    chk("noarm_capen", 32'(oCapEn), 0);
    chk("noarm_we",    32'(oMemWE), 0);

    iStart = 1'b0;
    cyc(2);
    iStart = 1'b1;
    cyc(3);
    frame(10);
    chk("hold_once_led", 32'(oLed), 0);
    wr(15'd0, 10'h3FF);
    chk("settle_wr_drop", 32'(oMemWE), 0);
    frame(1);
    frame(1);
    chk("settle3_led", 32'(oLed), 0);
    frame(1);
    chk("cap_led",       32'(oLed),   1);
    chk("capen_lag",     32'(oCapEn), 0);
    cyc(1);
    chk("capen_high",    32'(oCapEn),   1);
    chk("cap_done",      32'(oDone),    0);
    chk("cap_cnt0",      32'(oWrCount), 0);

    iRdReq = 1'b1; iRdAddr = 15'd7;
    cyc(1);
    iRdReq = 1'b0;
    chk("cap_rd_addr", 32'(oMemAddr), 0);
    cyc(1);
    chk("cap_rd_vld",  32'(oRdValid), 0);

    wr(15'd0, 10'h2A1);
    chk("wr0_we",   32'(oMemWE),   1);
    chk("wr0_addr", 32'(oMemAddr), 0);
    chk("wr0_data", 32'(oMemData), 32'h2A1);
    wr(15'd1, 10'h155);
    chk("wr1_addr", 32'(oMemAddr), 1);
    chk("wr1_data", 32'(oMemData), 32'h155);
    wr(15'd2, 10'h3C7);
    chk("wr2_data", 32'(oMemData), 32'h3C7);
    wr(15'd19199, 10'h111);
    chk("wrtop_we",   32'(oMemWE),   1);
    chk("wrtop_addr", 32'(oMemAddr), 19199);
    chk("wrtop_ovr",  32'(oOverrun), 0);
    wr(15'd19200, 10'h222);
    chk("wrovr_we",   32'(oMemWE),   0);
    chk("wrovr_ovr",  32'(oOverrun), 1);
    chk("wrovr_addr", 32'(oMemAddr), 19199);
    chk("wrovr_data", 32'(oMemData), 32'h111);
    chk("wrovr_cnt",  32'(oWrCount), 4);

    iX = 13'd143; iY = 13'd34;
    cyc(1);
    iX = 13'd0; iY = 13'd0;
    iWrReq = 1'b1; iWrAddr = 15'd3; iWrData = 10'h0AB;
    cyc(1);
    iWrReq = 1'b0;
    chk("endfs_we",    32'(oMemWE),   1);
    chk("endfs_addr",  32'(oMemAddr), 3);
    chk("endfs_done",  32'(oDone),    1);
    chk("endfs_capen", 32'(oCapEn),   0);
    chk("endfs_cnt",   32'(oWrCount), 5);

    wr(15'd4, 10'h050);
    chk("rdo_wr_we",  32'(oMemWE),   0);
    chk("rdo_wr_cnt", 32'(oWrCount), 5);
    iStart = 1'b0;
    cyc(3);
    chk("rdo_ign_start", 32'(oDone), 1);

    iRdReq = 1'b1; iRdAddr = 15'd0;
    cyc(1);
    chk("rd0_addr", 32'(oMemAddr), 0);
    chk("rd0_vld",  32'(oRdValid), 0);
    iRdAddr = 15'd1;
    cyc(1);
    chk("rd1_addr", 32'(oMemAddr), 1);
    chk("rd0_q_v",  32'(oRdValid), 1);
    chk("rd0_q",    32'(oRdData),  32'h2A1);
    iRdAddr = 15'd2;
    cyc(1);
    chk("rd2_addr", 32'(oMemAddr), 2);
    chk("rd1_q_v",  32'(oRdValid), 1);
    chk("rd1_q",    32'(oRdData),  32'h155);
    iRdReq = 1'b0; iRdDone = 1'b1;
    cyc(1);
    iRdDone = 1'b0;
    chk("rd2_q_v",   32'(oRdValid), 1);
    chk("rd2_q",     32'(oRdData),  32'h3C7);
    chk("rddone_led",  32'(oLed),   0);
    chk("rddone_done", 32'(oDone),  0);
    cyc(1);
    chk("rd_idle_vld", 32'(oRdValid), 0);

    iStart = 1'b0;
    cyc(2);
    iStart = 1'b1;
    cyc(3);
    chk("rearm_cnt", 32'(oWrCount), 0);
    chk("rearm_ovr", 32'(oOverrun), 0);
    repeat (4) frame(1);
    cyc(1);
    chk("ab_capen", 32'(oCapEn), 1);
    wr(15'd10, 10'h0AA);
    chk("ab_cnt1", 32'(oWrCount), 1);
    iStart = 1'b0;
    iWrReq = 1'b1; iWrAddr = 15'd11; iWrData = 10'h0BB;
    cyc(1);
    iWrReq = 1'b0;
    chk("ab_wr_we",   32'(oMemWE),   1);
    chk("ab_wr_addr", 32'(oMemAddr), 11);
    chk("ab_cnt2",    32'(oWrCount), 2);
    cyc(1);
    chk("ab_capen0", 32'(oCapEn), 0);
    chk("ab_led0",   32'(oLed),   0);
    chk("ab_we0",    32'(oMemWE), 0);
    frame(1);
    frame(1);
    chk("ab_nodone", 32'(oDone), 0);

    arm_and_capture();
    chk("ar_capen", 32'(oCapEn), 1);
    wr(15'd12, 10'h0CC);
    chk("ar_we1", 32'(oMemWE), 1);
    #1 iRST_N = 1'b0;
    #1;
    chk("ar_we0",    32'(oMemWE),   0);
    chk("ar_led0",   32'(oLed),     0);
    chk("ar_cnt0",   32'(oWrCount), 0);
    chk("ar_capen0", 32'(oCapEn),   0);
    cyc(2);
    iRST_N = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
